rx_phase_slicer: RTL and testbench
==================================

Name: rx_phase_slicer

Overview:
Receive-side counterpart of the polyphase TX shaping filter. Takes the OS-rate filtered sample stream, finds the sampling phase with the most energy over a search window, and locks to it. In lock it decimates by OS and slices each symbol to one bit (sign decision). Sits between the RX matched filter and the BER/bit-sink logic.

Parameters:
NB, 8, sample width (signed S(NB,NBF))
NBF, 7, fractional bits of the sample (informational only; slicing uses the sign bit)
OS, 4, oversampling factor; power of 2, ≥2
NSYM_SEARCH, 256, symbols per phase-search window; power of 2
NB_ACC, NB+1+$clog2(NSYM_SEARCH), energy accumulator width (localparam)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
i_data  in  NB  signed filtered sample
i_valid  in  1  sample strobe; one sample per strobe
i_enable  in  1  block enable; when low, all state frozen
i_restart  in  1  synchronous pulse: drop lock, restart search
o_bit  out  1  decided bit (1 = negative sample)
o_valid  out  1  one-cycle pulse, o_bit is valid
o_phase  out  $clog2(OS)  selected sampling phase
o_locked  out  1  high while in LOCK

Behaviour:
- Accepted sample = i_valid && i_enable. Nothing advances on a cycle without an accepted sample, except the reset, i_restart and search-end actions listed below.
- Reset (reset==0, async): state=IDLE. phase_cnt=0, sym_cnt=0, all accumulators=0. o_bit=0, o_valid=0, o_phase=0, o_locked=0.
- phase_cnt: +1 per accepted sample, modulo OS (OS-1 wraps to 0).
- sym_cnt: +1 on each accepted sample where phase_cnt==OS-1.
- FSM IDLE: moves to SEARCH on the first cycle with i_enable=1. That cycle's sample is already accumulated.
- FSM SEARCH:
  - Per accepted sample, acc[phase_cnt] += |i_data|.
  - Absolute value is computed in NB+1 bits, so -2^(NB-1) gives +2^(NB-1). No saturation is needed because NB_ACC cannot overflow.
  - Search ends on the accepted sample where phase_cnt==OS-1 and sym_cnt==NSYM_SEARCH-1, including that sample's contribution.
  - At the next edge: o_phase = index of the max accumulator (ties go to the lowest index), o_locked=1, state=LOCK, accumulators cleared, sym_cnt=0.
- FSM LOCK:
  - For an accepted sample with phase_cnt==o_phase, the next edge sets o_bit=i_data[NB-1] and o_valid=1. Latency is 1 cycle.
  - o_valid is 0 on every other cycle.
  - A zero sample decides bit 0.
- i_restart (sync, checked when i_enable=1, priority over sample processing):
  - Next edge sets state=SEARCH, accumulators=0, sym_cnt=0, phase_cnt=0, o_locked=0, o_valid=0.
  - o_phase holds its old value.
  - The sample in the restart cycle is discarded.
- i_enable low: i_valid ignored, o_valid forced 0 next edge, counters, accumulators and state held.
- Reset mid-LOCK or mid-SEARCH: immediate return to reset values; no partial output.

Optional Feature:
RX_PHASE_FORCE_EN
- Defined: adds ports i_force (1 bit) and i_force_phase ($clog2(OS) bits).
  - While i_force=1, the FSM goes directly to LOCK on the next edge with o_phase=i_force_phase, skipping the search.
  - o_phase tracks i_force_phase every cycle while forced.
  - On deassert of i_force, the block stays LOCKed at the last forced phase.
- Undefined: ports absent; phase comes only from the search.

Test Plan:
- Search and lock: reset, enable, 256 symbols with per-symbol samples [+5,+20,+100,+20] × random sign per symbol → at the edge after sample 1024, o_locked=1 and o_phase=2. Next symbols then give o_valid pulses with o_bit = sign of the phase-2 sample, 1-cycle latency, one pulse per 4 accepted samples.
- Tie and extreme values: all-zero input for 256 symbols → o_phase=0. Then restart and feed -128 at phase 3 only, else 0 → o_phase=3, with no accumulator overflow.
- Gapped strobes: i_valid every 3rd cycle, i_enable toggled low for 10 cycles mid-search → lock phase and timing identical to the gap-free run, with no o_valid during disable.
- Restart mid-LOCK: assert i_restart for 1 cycle → o_locked=0 and o_valid=0 next edge, o_phase held. Re-lock after exactly 1024 further accepted samples.
- Async reset mid-LOCK: pull reset low between clock edges → outputs 0 immediately. After release, IDLE→SEARCH on the first i_enable cycle.
- (RX_PHASE_FORCE_EN) i_force=1, i_force_phase=1 → o_locked=1 and o_phase=1 next edge. Decisions are taken from the phase-1 sample.

Source files
------------

// File: rtl/rx_phase_slicer.sv
// RX sampling-phase search and sign slicer: picks the max-energy phase over a window, then decimates by OS.
// Optional RX_PHASE_FORCE_EN adds i_force/i_force_phase to bypass the search with a fixed phase.
module rx_phase_slicer #(
    parameter int NB          = 8,
    parameter int NBF         = 7,
    parameter int OS          = 4,
    parameter int NSYM_SEARCH = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic signed [NB-1:0]  i_data,
    input  logic                  i_valid,
    input  logic                  i_enable,
    input  logic                  i_restart,
`ifdef RX_PHASE_FORCE_EN
    input  logic                  i_force,
    input  logic [$clog2(OS)-1:0] i_force_phase,
`endif
    output logic                  o_bit,
    output logic                  o_valid,
    output logic [$clog2(OS)-1:0] o_phase,
    output logic                  o_locked
);

    localparam int NB_ACC = NB + 1 + $clog2(NSYM_SEARCH);
    localparam int PW     = $clog2(OS);
    localparam int SW     = $clog2(NSYM_SEARCH);

    localparam logic [PW-1:0] PH_LAST  = PW'(OS - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(NSYM_SEARCH - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCK   = 2'd2;

    if (NBF >= NB || OS < 2 || NSYM_SEARCH < 2) begin : g_cfg_check
        $error("rx_phase_slicer: invalid parameter set");
    end

    logic [1:0]        state;
    logic [PW-1:0]     phase_cnt;
    logic [SW-1:0]     sym_cnt;
    logic [NB_ACC-1:0] acc      [OS];
    logic [NB_ACC-1:0] acc_next [OS];
    logic [NB_ACC-1:0] best_val;
    logic [PW-1:0]     best_idx;
    logic [NB:0]       data_ext;
    logic [NB:0]       mag;
    logic              accepted;
    logic              search_end;
    logic              force_now;
    logic [PW-1:0]     force_phase;
    logic [PW-1:0]     dec_phase;

    always_comb begin
        accepted = i_valid && i_enable;
        // Sign-extend first so -2^(NB-1) negates to +2^(NB-1) without wrapping.
        data_ext = {i_data[NB-1], i_data};
        mag      = data_ext[NB] ? ((~data_ext) + 1'b1) : data_ext;
        for (int unsigned i = 0; i < OS; i++) begin
            acc_next[i] = acc[i];
            if (accepted && phase_cnt == PW'(i)) begin
                acc_next[i] = acc[i] + NB_ACC'(mag);
            end
        end
        best_idx = '0;
        best_val = acc_next[0];
        for (int unsigned i = 1; i < OS; i++) begin
            if (acc_next[i] > best_val) begin
                best_val = acc_next[i];
                best_idx = PW'(i);
            end
        end
        search_end = accepted && (state != ST_LOCK) &&
                     (phase_cnt == PH_LAST) && (sym_cnt == SYM_LAST);
`ifdef RX_PHASE_FORCE_EN
        force_now   = i_force;
        force_phase = i_force_phase;
        dec_phase   = i_force ? i_force_phase : o_phase;
`else
        force_now   = 1'b0;
        force_phase = o_phase;
        dec_phase   = o_phase;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            sym_cnt   <= '0;
            for (int unsigned i = 0; i < OS; i++) acc[i] <= '0;
            o_bit     <= 1'b0;
            o_valid   <= 1'b0;
            o_phase   <= '0;
            o_locked  <= 1'b0;
        end else if (i_enable) begin
            o_valid <= 1'b0;
            if (i_restart) begin
                state     <= ST_SEARCH;
                phase_cnt <= '0;
                sym_cnt   <= '0;
                for (int unsigned i = 0; i < OS; i++) acc[i] <= '0;
                o_locked  <= 1'b0;
            end else begin
                if (accepted) begin
                    phase_cnt <= phase_cnt + 1'b1;
                    if (phase_cnt == PH_LAST) sym_cnt <= sym_cnt + 1'b1;
                end
                if (force_now) begin
                    state    <= ST_LOCK;
                    o_phase  <= force_phase;
                    o_locked <= 1'b1;
                end else if (state != ST_LOCK) begin
                    // IDLE falls into SEARCH on its first enabled cycle, sample included.
                    state <= ST_SEARCH;
                    for (int unsigned i = 0; i < OS; i++) begin
                        acc[i] <= search_end ? '0 : acc_next[i];
                    end
                    if (search_end) begin
                        state    <= ST_LOCK;
                        o_phase  <= best_idx;
                        o_locked <= 1'b1;
                        sym_cnt  <= '0;
                    end
                end
                if ((state == ST_LOCK || force_now) && accepted && phase_cnt == dec_phase) begin
                    o_bit   <= i_data[NB-1];
                    o_valid <= 1'b1;
                end
            end
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_phase_slicer.sv
// Scoreboard bench for rx_phase_slicer: stimulus queues expected decisions, a negedge monitor checks them.
// Define RX_PHASE_FORCE_EN to also exercise the forced-phase ports.
module tb_rx_phase_slicer;

    logic              clock = 1'b0;
    logic              reset;
    logic signed [7:0] i_data;
    logic              i_valid;
    logic              i_enable;
    logic              i_restart;
    logic              o_bit;
    logic              o_valid;
    logic [1:0]        o_phase;
    logic              o_locked;
`ifdef RX_PHASE_FORCE_EN
    logic              i_force;
    logic [1:0]        i_force_phase;
`endif

    rx_phase_slicer #(.NB(8), .NBF(7), .OS(4), .NSYM_SEARCH(256)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_enable      (i_enable),
        .i_restart     (i_restart),
`ifdef RX_PHASE_FORCE_EN
        .i_force       (i_force),
        .i_force_phase (i_force_phase),
`endif
        .o_bit         (o_bit),
        .o_valid       (o_valid),
        .o_phase       (o_phase),
        .o_locked      (o_locked)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic b;
        int   c;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;
    int   phase_idx = 0;
    int   exp_phase = 0;
    bit   tb_locked = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Decisions are due on the edge after their sample; anything early, late or extra is flagged.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].c < cyc) begin
            mon_e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missing_decision: got no o_valid at cycle %0d, required bit=%0b", mon_e.c, mon_e.b);
        end
        if (o_valid) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL spurious_valid: got o_valid=1 at cycle %0d, required o_valid=0", cyc);
            end else begin
                mon_e = q.pop_front();
                if (o_bit !== mon_e.b || cyc != mon_e.c) begin
                    bad++;
                    $display("FAIL decision: got bit=%0b cycle=%0d, required bit=%0b cycle=%0d",
                             o_bit, cyc, mon_e.b, mon_e.c);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic signed [7:0] d, input logic v, input logic en, input logic rs);
        @(negedge clock);
        i_data    = d;
        i_valid   = v;
        i_enable  = en;
        i_restart = rs;
        if (en && rs) begin
            phase_idx = 0;
            tb_locked = 1'b0;
        end else if (en && v) begin
            if (tb_locked && phase_idx == exp_phase) q.push_back('{b: d[7], c: cyc + 1});
            phase_idx = (phase_idx + 1) % 4;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_search(input int v0, input int v1, input int v2, input int v3, input bit rnd,
                              input int gap, input int dis_at, input int ph, input string tag);
        int                vals[4];
        logic              neg;
        logic signed [7:0] d;
        vals = '{v0, v1, v2, v3};
        neg  = 1'b0;
        for (int k = 0; k < 1024; k++) begin
            if (k % 4 == 0) neg = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            d = 8'(neg ? -vals[k % 4] : vals[k % 4]);
            if (k == dis_at) repeat (10) step(d, 1'b1, 1'b0, 1'b0);
            repeat (gap) step(8'sd0, 1'b0, 1'b1, 1'b0);
            if (k == 1023) check({tag, "_prelock"}, int'(o_locked), 0);
            step(d, 1'b1, 1'b1, 1'b0);
        end
        check({tag, "_locked"}, int'(o_locked), 1);
        check({tag, "_phase"}, int'(o_phase), ph);
        exp_phase = ph;
        tb_locked = 1'b1;
    endtask

    task automatic lock_syms(input int n, input int v0, input int v1, input int v2, input int v3,
                             input bit rnd, input int gap);
        int                vals[4];
        logic              neg;
        logic signed [7:0] d;
        vals = '{v0, v1, v2, v3};
        for (int s = 0; s < n; s++) begin
            neg = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            for (int k = 0; k < 4; k++) begin
                d = 8'(neg ? -vals[k] : vals[k]);
                repeat (gap) step(8'sd0, 1'b0, 1'b1, 1'b0);
                step(d, 1'b1, 1'b1, 1'b0);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        i_data    = '0;
        i_valid   = 1'b0;
        i_enable  = 1'b0;
        i_restart = 1'b0;
`ifdef RX_PHASE_FORCE_EN
        i_force       = 1'b0;
        i_force_phase = '0;
`endif
        repeat (2) @(negedge clock);
        check("rst_bit", int'(o_bit), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_phase", int'(o_phase), 0);
        check("rst_locked", int'(o_locked), 0);
        reset = 1'b1;
        step(8'sd0, 1'b0, 1'b0, 1'b0);
        check("idle_unlocked", int'(o_locked), 0);

        // Main search: phase 2 carries the energy.
        run_search(5, 20, 100, 20, 1'b1, 0, -1, 2, "search");
        lock_syms(6, 5, 20, 100, 20, 1'b1, 0);
        lock_syms(1, 5, 20, 0, 20, 1'b1, 0);
        repeat (3) step(8'sd0, 1'b0, 1'b1, 1'b0);
        step(8'sd5, 1'b1, 1'b1, 1'b0);
        step(8'sd20, 1'b1, 1'b1, 1'b0);
        step(-8'sd100, 1'b1, 1'b1, 1'b0);
        step(8'sd20, 1'b1, 1'b0, 1'b0);
        check("disable_valid_low", int'(o_valid), 0);
        step(8'sd20, 1'b1, 1'b1, 1'b0);

        // Restart on what would be a decision sample: it must be dropped.
        step(8'sd5, 1'b1, 1'b1, 1'b0);
        step(8'sd20, 1'b1, 1'b1, 1'b0);
        step(-8'sd100, 1'b1, 1'b1, 1'b1);
        check("restart_locked", int'(o_locked), 0);
        check("restart_valid", int'(o_valid), 0);
        check("restart_phase_held", int'(o_phase), 2);

        run_search(0, 0, 0, 0, 1'b0, 0, -1, 0, "tie_zero");
        lock_syms(2, 0, 0, 0, 0, 1'b0, 0);
        step(8'sd0, 1'b0, 1'b1, 1'b1);
        check("restart2_phase_held", int'(o_phase), 0);
        run_search(0, 0, 0, -128, 1'b0, 0, -1, 3, "extreme");
        lock_syms(2, 0, 0, 0, -128, 1'b0, 0);

        // Sparse strobes with a disable burst mid-search.
        step(8'sd0, 1'b0, 1'b1, 1'b1);
        run_search(5, 20, 100, 20, 1'b1, 2, 500, 2, "gapped");
        lock_syms(3, 5, 20, 100, 20, 1'b1, 2);
        repeat (12) step(8'sd100, 1'b1, 1'b0, 1'b0);
        lock_syms(2, 5, 20, 100, 20, 1'b1, 2);

        // Async reset between edges while locked.
        repeat (2) step(8'sd0, 1'b0, 1'b1, 1'b0);
        #3;
        reset    = 1'b0;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        #1;
        check("async_locked", int'(o_locked), 0);
        check("async_phase", int'(o_phase), 0);
        check("async_valid", int'(o_valid), 0);
        phase_idx = 0;
        tb_locked = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step(8'sd0, 1'b0, 1'b0, 1'b0);
        check("post_rst_unlocked", int'(o_locked), 0);
        run_search(3, 60, 3, 3, 1'b1, 0, -1, 1, "post_rst");
        lock_syms(3, 3, 60, 3, 3, 1'b1, 0);

`ifdef RX_PHASE_FORCE_EN
        step(8'sd0, 1'b0, 1'b1, 1'b1);
        check("force_pre_locked", int'(o_locked), 0);
        @(negedge clock);
        i_force       = 1'b1;
        i_force_phase = 2'd2;
        step(8'sd0, 1'b0, 1'b1, 1'b0);
        check("force_locked", int'(o_locked), 1);
        check("force_phase2", int'(o_phase), 2);
        @(negedge clock);
        i_force_phase = 2'd1;
        step(8'sd0, 1'b0, 1'b1, 1'b0);
        check("force_phase1", int'(o_phase), 1);
        @(negedge clock);
        i_force   = 1'b0;
        exp_phase = 1;
        tb_locked = 1'b1;
        lock_syms(4, 90, 7, 90, 90, 1'b1, 0);
        check("force_hold_phase", int'(o_phase), 1);
        check("force_hold_locked", int'(o_locked), 1);
`endif

        repeat (3) step(8'sd0, 1'b0, 1'b1, 1'b0);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
